// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) memory arbiter with tag-tracked load returns.
// The dcache has priority, and a starvation counter hands a waiting icache the bus.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TAG_W        = 4,
  parameter int XLEN         = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_icache_req_valid,
  input  logic [XLEN-1:0]   i_icache_req_addr,
  input  logic [1:0]        i_dcache_req_cmd,
  input  logic [XLEN-1:0]   i_dcache_req_addr,
  input  logic [63:0]       i_dcache_req_data,
  input  logic [TAG_W-1:0]  i_mem2proc_response,
  input  logic [63:0]       i_mem2proc_data,
  input  logic [TAG_W-1:0]  i_mem2proc_tag,
  output logic [1:0]        o_proc2mem_command,
  output logic [XLEN-1:0]   o_proc2mem_addr,
  output logic [63:0]       o_proc2mem_data,
  output logic              o_icache_grant,
  output logic              o_dcache_grant,
  output logic              o_icache_resp_valid,
  output logic [63:0]       o_icache_resp_data,
  output logic              o_dcache_resp_valid,
  output logic [63:0]       o_dcache_resp_data,
  output logic [TAG_W:0]    o_icache_outstanding,
  output logic [TAG_W:0]    o_dcache_outstanding,
  output logic              o_err_unexpected_tag
);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam int         NTAG     = 1 << TAG_W;
  localparam int         SW       = (STARVE_LIMIT < 8) ? 3 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0]  STARVE_ONE = SW'(1);
  localparam logic [TAG_W:0] CNT_ONE    = (TAG_W + 1)'(1);

  logic [SW-1:0]    r_starve_cnt;
  logic [NTAG-1:0]  r_valid;
  logic [NTAG-1:0]  r_owner;   // 0 = icache, 1 = dcache
  logic [TAG_W:0]   r_ic_cnt;
  logic [TAG_W:0]   r_dc_cnt;

  logic [SW-1:0]    w_starve_eff;
  logic [SW-1:0]    w_starve_next;
  logic [NTAG-1:0]  w_valid_eff;
  logic [NTAG-1:0]  w_valid_next;
  logic [NTAG-1:0]  w_owner_next;
  logic [TAG_W:0]   w_ic_cnt_next;
  logic [TAG_W:0]   w_dc_cnt_next;
  logic             w_dc_req;
  logic             w_ic_wins;
  logic             w_dc_wins;
  logic             w_accepted;
  logic             w_load_grant;
  logic             w_ret_live;
  logic             w_ret_hit;

  // While reset is held, everything combinational already sees the cleared state.
  assign w_valid_eff  = reset ? '0 : r_valid;
  assign w_starve_eff = reset ? '0 : r_starve_cnt;

  assign w_dc_req   = (i_dcache_req_cmd != BUS_NONE);
  assign w_ic_wins  = i_icache_req_valid && (!w_dc_req || (w_starve_eff >= STARVE_MAX));
  assign w_dc_wins  = w_dc_req && !w_ic_wins;
  assign w_accepted = (i_mem2proc_response != '0);

  assign o_icache_grant = w_ic_wins && w_accepted;
  assign o_dcache_grant = w_dc_wins && w_accepted;

  always_comb begin
    o_proc2mem_command = BUS_NONE;
    o_proc2mem_addr    = '0;
    o_proc2mem_data    = '0;
    if (w_ic_wins) begin
      o_proc2mem_command = BUS_LOAD;
      o_proc2mem_addr    = i_icache_req_addr;
    end else if (w_dc_wins) begin
      o_proc2mem_command = i_dcache_req_cmd;
      o_proc2mem_addr    = i_dcache_req_addr;
      o_proc2mem_data    = i_dcache_req_data;
    end
  end

  assign w_load_grant = o_icache_grant || (o_dcache_grant && (i_dcache_req_cmd == BUS_LOAD));

  assign w_ret_live = (i_mem2proc_tag != '0);
  assign w_ret_hit  = w_ret_live && w_valid_eff[i_mem2proc_tag];

  assign o_icache_resp_valid  = w_ret_hit && !r_owner[i_mem2proc_tag];
  assign o_dcache_resp_valid  = w_ret_hit &&  r_owner[i_mem2proc_tag];
  assign o_icache_resp_data   = i_mem2proc_data;
  assign o_dcache_resp_data   = i_mem2proc_data;
  assign o_err_unexpected_tag = w_ret_live && !w_valid_eff[i_mem2proc_tag];

  // Retire before allocate, so a tag returned and reissued in one cycle ends up live.
  always_comb begin
    w_valid_next = w_valid_eff;
    w_owner_next = r_owner;
    if (w_ret_hit) begin
      w_valid_next[i_mem2proc_tag] = 1'b0;
    end
    if (w_load_grant) begin
      w_valid_next[i_mem2proc_response] = 1'b1;
      w_owner_next[i_mem2proc_response] = w_dc_wins;
    end
  end

  // Counts are taken from the next table so overwritten entries stay consistent.
  always_comb begin
    w_ic_cnt_next = '0;
    w_dc_cnt_next = '0;
    for (int k = 0; k < NTAG; k++) begin
      if (w_valid_next[k]) begin
        if (w_owner_next[k]) begin
          w_dc_cnt_next = w_dc_cnt_next + CNT_ONE;
        end else begin
          w_ic_cnt_next = w_ic_cnt_next + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    w_starve_next = '0;
    if (i_icache_req_valid && !o_icache_grant) begin
      w_starve_next = (w_starve_eff >= STARVE_MAX) ? STARVE_MAX : (w_starve_eff + STARVE_ONE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_starve_cnt <= '0;
      r_valid      <= '0;
      r_owner      <= '0;
      r_ic_cnt     <= '0;
      r_dc_cnt     <= '0;
    end else begin
      r_starve_cnt <= w_starve_next;
      r_valid      <= w_valid_next;
      r_owner      <= w_owner_next;
      r_ic_cnt     <= w_ic_cnt_next;
      r_dc_cnt     <= w_dc_cnt_next;
    end
  end

  assign o_icache_outstanding = reset ? '0 : r_ic_cnt;
  assign o_dcache_outstanding = reset ? '0 : r_dc_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// tag-ownership model (one owner slot per tag, -1 meaning free).
module tb_mem_arbiter;
  localparam int TAG_W = 4;
  localparam int XLEN  = 32;
  localparam int LIM   = 4;
  localparam int NTAG  = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              icv;
  logic [XLEN-1:0]   iaddr;
  logic [1:0]        dcmd;
  logic [XLEN-1:0]   daddr;
  logic [63:0]       ddata;
  logic [TAG_W-1:0]  resp;
  logic [63:0]       rdata;
  logic [TAG_W-1:0]  rtag;

  logic [1:0]        o_cmd;
  logic [XLEN-1:0]   o_addr;
  logic [63:0]       o_data;
  logic              o_igr, o_dgr, o_irv, o_drv, o_err;
  logic [63:0]       o_ird, o_drd;
  logic [TAG_W:0]    o_ic_out, o_dc_out;

  mem_arbiter #(.STARVE_LIMIT(LIM), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .i_icache_req_valid(icv), .i_icache_req_addr(iaddr),
    .i_dcache_req_cmd(dcmd), .i_dcache_req_addr(daddr), .i_dcache_req_data(ddata),
    .i_mem2proc_response(resp), .i_mem2proc_data(rdata), .i_mem2proc_tag(rtag),
    .o_proc2mem_command(o_cmd), .o_proc2mem_addr(o_addr), .o_proc2mem_data(o_data),
    .o_icache_grant(o_igr), .o_dcache_grant(o_dgr),
    .o_icache_resp_valid(o_irv), .o_icache_resp_data(o_ird),
    .o_dcache_resp_valid(o_drv), .o_dcache_resp_data(o_drd),
    .o_icache_outstanding(o_ic_out), .o_dcache_outstanding(o_dc_out),
    .o_err_unexpected_tag(o_err)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  int m_owner[NTAG];
  int m_starve;
  logic [1:0]      e_cmd;
  logic [XLEN-1:0] e_addr;
  logic [63:0]     e_data;
  logic            e_igr, e_dgr, e_irv, e_drv, e_err;
  int              e_ic_out, e_dc_out;

  bit p_have = 0;
  bit p_rst, p_icv, p_igr, p_load;
  int p_clear, p_tag, p_own;

  function automatic int m_count(int who);
    int c = 0;
    for (int t = 0; t < NTAG; t++) if (m_owner[t] == who) c++;
    return c;
  endfunction

  task automatic model_commit();
    if (p_clear != 0) m_owner[p_clear] = -1;
    if (p_load) m_owner[p_tag] = p_own;
    if (p_icv && !p_igr) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
    else m_starve = 0;
    if (p_rst) begin
      for (int t = 0; t < NTAG; t++) m_owner[t] = -1;
      m_starve = 0;
    end
  endtask

  task automatic model_predict();
    bit dc_req, ic_w, dc_w;
    if (reset) begin
      for (int t = 0; t < NTAG; t++) m_owner[t] = -1;
      m_starve = 0;
    end
    dc_req = (dcmd != 2'd0);
    ic_w   = icv && (!dc_req || m_starve >= LIM);
    dc_w   = dc_req && !ic_w;
    e_cmd  = ic_w ? 2'd1 : (dc_w ? dcmd : 2'd0);
    e_addr = ic_w ? iaddr : (dc_w ? daddr : '0);
    e_data = dc_w ? ddata : 64'd0;
    e_igr  = ic_w && (resp != 0);
    e_dgr  = dc_w && (resp != 0);
    e_irv  = (rtag != 0) && (m_owner[rtag] == 0);
    e_drv  = (rtag != 0) && (m_owner[rtag] == 1);
    e_err  = (rtag != 0) && (m_owner[rtag] < 0);
    e_ic_out = m_count(0);
    e_dc_out = m_count(1);
    p_rst   = reset;
    p_icv   = icv;
    p_igr   = e_igr;
    p_clear = (e_irv || e_drv) ? int'(rtag) : 0;
    p_load  = e_igr || (e_dgr && dcmd == 2'd1);
    p_tag   = int'(resp);
    p_own   = e_igr ? 0 : 1;
    p_have  = 1;
  endtask

  task automatic drive(input logic rst, input logic ic_v, input logic [XLEN-1:0] ia,
                       input logic [1:0] dc, input logic [XLEN-1:0] da, input logic [63:0] dd,
                       input logic [TAG_W-1:0] rs, input logic [TAG_W-1:0] rt, input logic [63:0] rd);
    @(negedge clock);
    if (p_have) model_commit();
    reset = rst; icv = ic_v; iaddr = ia; dcmd = dc; daddr = da; ddata = dd;
    resp = rs; rtag = rt; rdata = rd;
    #1;
    model_predict();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_dut();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 2'd1, 32'h100, 0, 4'd3, 0, 0);
    n_tests++; if ({o_cmd, o_dgr, o_igr} !== {2'd1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL reset_comb got cmd=%0d dgr=%0b igr=%0b want 1 1 0", o_cmd, o_dgr, o_igr); end
    n_tests++; if ({o_ic_out, o_dc_out} !== 10'd0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", o_ic_out, o_dc_out); end
    idle();
    n_tests++; if ({o_cmd, o_addr, o_data} !== '0) begin n_fail++; $display("FAIL reset_idle_bus got cmd=%0d addr=%h data=%h want 0", o_cmd, o_addr, o_data); end
    n_tests++; if (o_dc_out !== 5'd0) begin n_fail++; $display("FAIL reset_drop_load got %0d want 0", o_dc_out); end
  endtask

  task automatic test_dcache_priority();
    reset_dut();
    drive(0, 1, 32'h40, 2'd1, 32'h100, 0, 4'd3, 0, 0);
    n_tests++; if ({o_dgr, o_igr} !== 2'b10) begin n_fail++; $display("FAIL prio_grants got d=%0b i=%0b want 1 0", o_dgr, o_igr); end
    n_tests++; if ({o_cmd, o_addr} !== {2'd1, 32'h100}) begin n_fail++; $display("FAIL prio_bus got cmd=%0d addr=%h want 1 100", o_cmd, o_addr); end
    idle();
    n_tests++; if ({o_ic_out, o_dc_out} !== {5'd0, 5'd1}) begin n_fail++; $display("FAIL prio_count got %0d/%0d want 0/1", o_ic_out, o_dc_out); end
    drive(0, 0, 0, 0, 0, 0, 0, 4'd3, 64'hDEAD);
    n_tests++; if ({o_drv, o_irv, o_err} !== 3'b100) begin n_fail++; $display("FAIL prio_resp got drv=%0b irv=%0b err=%0b want 1 0 0", o_drv, o_irv, o_err); end
    n_tests++; if (o_drd !== 64'hDEAD) begin n_fail++; $display("FAIL prio_data got %h want dead", o_drd); end
    idle();
    n_tests++; if (o_dc_out !== 5'd0) begin n_fail++; $display("FAIL prio_retire got %0d want 0", o_dc_out); end
  endtask

  task automatic test_starvation();
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 32'h1000 + 8 * i, 2'd1, 32'h2000 + 8 * i, 64'h77, 4'(i + 1), 0, 0);
      n_tests++; if ({o_igr, o_dgr} !== ((i == 4) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL starve_cycle%0d got i=%0b d=%0b", i, o_igr, o_dgr); end
      if (i == 4) begin
        n_tests++; if ({o_cmd, o_addr, o_data} !== {2'd1, 32'h1020, 64'd0}) begin n_fail++; $display("FAIL starve_bus got cmd=%0d addr=%h data=%h want 1 1020 0", o_cmd, o_addr, o_data); end
      end
    end
    idle();
    n_tests++; if ({o_ic_out, o_dc_out} !== {5'd1, 5'd5}) begin n_fail++; $display("FAIL starve_counts got %0d/%0d want 1/5", o_ic_out, o_dc_out); end
  endtask

  task automatic test_store();
    reset_dut();
    drive(0, 0, 0, 2'd2, 32'h200, 64'h55, 4'd5, 0, 0);
    n_tests++; if ({o_cmd, o_addr, o_data, o_dgr} !== {2'd2, 32'h200, 64'h55, 1'b1}) begin n_fail++; $display("FAIL store_bus got cmd=%0d addr=%h data=%h dgr=%0b", o_cmd, o_addr, o_data, o_dgr); end
    idle();
    n_tests++; if ({o_ic_out, o_dc_out} !== 10'd0) begin n_fail++; $display("FAIL store_count got %0d/%0d want 0/0", o_ic_out, o_dc_out); end
    drive(0, 0, 0, 0, 0, 0, 0, 4'd5, 64'h1);
    n_tests++; if ({o_irv, o_drv, o_err} !== 3'b001) begin n_fail++; $display("FAIL store_return got irv=%0b drv=%0b err=%0b want 0 0 1", o_irv, o_drv, o_err); end
  endtask

  task automatic test_reject();
    reset_dut();
    drive(0, 1, 32'h80, 0, 0, 0, 0, 0, 0);
    n_tests++; if ({o_igr, o_cmd, o_addr} !== {1'b0, 2'd1, 32'h80}) begin n_fail++; $display("FAIL reject_bus got igr=%0b cmd=%0d addr=%h", o_igr, o_cmd, o_addr); end
    idle();
    n_tests++; if (o_ic_out !== 5'd0) begin n_fail++; $display("FAIL reject_count got %0d want 0", o_ic_out); end
  endtask

  task automatic test_same_cycle();
    reset_dut();
    drive(0, 1, 32'h40, 0, 0, 0, 4'd2, 0, 0);
    drive(0, 0, 0, 2'd1, 32'h300, 0, 4'd2, 4'd2, 64'hBEEF);
    n_tests++; if ({o_ic_out, o_dc_out} !== {5'd1, 5'd0}) begin n_fail++; $display("FAIL same_pre got %0d/%0d want 1/0", o_ic_out, o_dc_out); end
    n_tests++; if ({o_irv, o_drv, o_dgr, o_err, o_ird} !== {4'b1010, 64'hBEEF}) begin n_fail++; $display("FAIL same_resp got irv=%0b drv=%0b dgr=%0b err=%0b data=%h", o_irv, o_drv, o_dgr, o_err, o_ird); end
    idle();
    n_tests++; if ({o_ic_out, o_dc_out} !== {5'd0, 5'd1}) begin n_fail++; $display("FAIL same_post got %0d/%0d want 0/1", o_ic_out, o_dc_out); end
    drive(0, 0, 0, 0, 0, 0, 0, 4'd2, 64'h1234);
    n_tests++; if ({o_drv, o_irv} !== 2'b10) begin n_fail++; $display("FAIL same_owner got drv=%0b irv=%0b want 1 0", o_drv, o_irv); end
  endtask

  task automatic test_overwrite();
    reset_dut();
    drive(0, 1, 32'h48, 0, 0, 0, 4'd7, 0, 0);
    drive(0, 0, 0, 2'd1, 32'h308, 0, 4'd7, 0, 0);
    n_tests++; if ({o_dgr, o_err} !== 2'b10) begin n_fail++; $display("FAIL ovw_grant got dgr=%0b err=%0b want 1 0", o_dgr, o_err); end
    idle();
    n_tests++; if ({o_ic_out, o_dc_out} !== {5'd0, 5'd1}) begin n_fail++; $display("FAIL ovw_count got %0d/%0d want 0/1", o_ic_out, o_dc_out); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    drive(0, 1, 32'h10, 0, 0, 0, 4'd1, 0, 0);
    drive(0, 1, 32'h18, 0, 0, 0, 4'd2, 0, 0);
    idle();
    n_tests++; if (o_ic_out !== 5'd2) begin n_fail++; $display("FAIL rmid_pre got %0d want 2", o_ic_out); end
    drive(1, 0, 0, 0, 0, 0, 0, 4'd2, 64'h9);
    n_tests++; if ({o_irv, o_drv, o_err} !== 3'b001) begin n_fail++; $display("FAIL rmid_during got irv=%0b drv=%0b err=%0b want 0 0 1", o_irv, o_drv, o_err); end
    drive(0, 0, 0, 0, 0, 0, 0, 4'd1, 64'h9);
    n_tests++; if ({o_irv, o_drv, o_err, o_ic_out, o_dc_out} !== {3'b001, 10'd0}) begin n_fail++; $display("FAIL rmid_after got irv=%0b drv=%0b err=%0b cnt=%0d/%0d", o_irv, o_drv, o_err, o_ic_out, o_dc_out); end
  endtask

  task automatic test_random();
    int live[$];
    logic [TAG_W-1:0] t_rt, t_rs;
    for (int c = 0; c < 600; c++) begin
      live.delete();
      for (int t = 1; t < NTAG; t++) if (m_owner[t] >= 0) live.push_back(t);
      if (live.size() > 0 && $urandom_range(0, 1) == 1) t_rt = 4'(live[$urandom_range(0, live.size() - 1)]);
      else t_rt = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      t_rs = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, 32'($urandom) & 32'hFFFF_FFF8,
            2'($urandom_range(0, 2)), 32'($urandom) & 32'hFFFF_FFF8, {$urandom, $urandom},
            t_rs, t_rt, {$urandom, $urandom});
      n_tests++; if ({o_cmd, o_addr, o_data} !== {e_cmd, e_addr, e_data}) begin n_fail++; $display("FAIL rand_bus c=%0d got %0d %h %h want %0d %h %h", c, o_cmd, o_addr, o_data, e_cmd, e_addr, e_data); end
      n_tests++; if ({o_igr, o_dgr, o_irv, o_drv, o_err} !== {e_igr, e_dgr, e_irv, e_drv, e_err}) begin n_fail++; $display("FAIL rand_flags c=%0d got %b want %b", c, {o_igr, o_dgr, o_irv, o_drv, o_err}, {e_igr, e_dgr, e_irv, e_drv, e_err}); end
      n_tests++; if ({o_ic_out, o_dc_out} !== {5'(e_ic_out), 5'(e_dc_out)}) begin n_fail++; $display("FAIL rand_counts c=%0d got %0d/%0d want %0d/%0d", c, o_ic_out, o_dc_out, e_ic_out, e_dc_out); end
      if (e_irv || e_drv) begin
        n_tests++; if ((e_irv ? o_ird : o_drd) !== rdata) begin n_fail++; $display("FAIL rand_data c=%0d got %h want %h", c, e_irv ? o_ird : o_drd, rdata); end
      end
    end
  endtask

  initial begin
    for (int t = 0; t < NTAG; t++) m_owner[t] = -1;
    m_starve = 0;
    reset = 1'b1; icv = 0; iaddr = 0; dcmd = 0; daddr = 0; ddata = 0;
    resp = 0; rdata = 0; rtag = 0;
    test_reset();
    test_dcache_priority();
    test_starvation();
    test_store();
    test_reject();
    test_same_cycle();
    test_overwrite();
    test_reset_mid();
    reset_dut();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
